// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM states, decode helpers.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LD    = 4'h1;
  localparam logic [3:0] OP_ST    = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;
  localparam logic [3:0] OP_LDI   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JC    = 4'hC;
  localparam logic [3:0] OP_RSV_D = 4'hD;
  localparam logic [3:0] OP_RSV_E = 4'hE;
  localparam logic [3:0] OP_HLT   = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_t;

  function automatic logic is_two_word(input logic [3:0] op);
    return op inside {OP_LD, OP_ST, OP_LDI, OP_JMP, OP_JZ, OP_JC};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for ADD/SUB/AND/OR/XOR; C is carry for ADD and borrow for SUB.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  always_comb begin
    result = a;
    c      = 1'b0;
    case (op)
      OP_ADD: {c, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      default: ;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU top: FSM, unified memory, register file, IO port.
// Define CPU_ILLEGAL_TRAP_EN to trap opcodes D/E instead of treating them as NOPs.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int REG_CNT = 4,
  parameter int IO_ADDR = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              io_valid,
  output logic [DATA_W-1:0] io_data
);

  localparam logic [ADDR_W-1:0] IO_A = ADDR_W'(IO_ADDR);

  logic [DATA_W-1:0] memory  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] regfile [0:REG_CNT-1];
  logic [ADDR_W-1:0] PC;
  logic [7:0]        instr;
  logic [DATA_W-1:0] opnd;
  logic              zf, cf;
  state_t            state;

  logic [3:0]        opcode;
  logic [1:0]        rd, rs;
  logic [DATA_W-1:0] mem_rd;
  logic [ADDR_W-1:0] opnd_addr;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_c;
  logic              trap_op;

  assign opcode    = instr[7:4];
  assign rd        = instr[3:2];
  assign rs        = instr[1:0];
  assign mem_rd    = memory[PC];
  assign opnd_addr = opnd[ADDR_W-1:0];
  assign pc_out    = PC;

`ifdef CPU_ILLEGAL_TRAP_EN
  assign trap_op = (opcode == OP_RSV_D) || (opcode == OP_RSV_E);
`else
  assign trap_op = 1'b0;
`endif

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (opcode),
    .a      (regfile[rd]),
    .b      (regfile[rs]),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  // retire/io_valid are raised on the transition into EXEC so they are high during EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      PC       <= '0;
      instr    <= '0;
      opnd     <= '0;
      zf       <= 1'b0;
      cf       <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      retire   <= 1'b0;
      io_valid <= 1'b0;
      io_data  <= '0;
      for (int unsigned i = 0; i < REG_CNT; i++) regfile[i] <= '0;
    end else begin
      retire   <= 1'b0;
      io_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          instr <= mem_rd[7:0];
          PC    <= PC + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (trap_op) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else if (is_two_word(opcode)) begin
            state <= S_OPERAND;
          end else begin
            state  <= S_EXEC;
            retire <= 1'b1;
          end
        end
        S_OPERAND: begin
          opnd   <= mem_rd;
          PC     <= PC + 1'b1;
          state  <= S_EXEC;
          retire <= 1'b1;
          if (opcode == OP_ST && mem_rd[ADDR_W-1:0] == IO_A) begin
            io_valid <= 1'b1;
            io_data  <= regfile[rd];
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (opcode)
            OP_LD:  regfile[rd] <= memory[opnd_addr];
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              regfile[rd] <= alu_res;
              zf          <= alu_z;
              cf          <= alu_c;
            end
            OP_MOV: regfile[rd] <= regfile[rs];
            OP_LDI: regfile[rd] <= opnd;
            OP_JMP: PC <= opnd_addr;
            OP_JZ:  if (zf) PC <= opnd_addr;
            OP_JC:  if (cf) PC <= opnd_addr;
            OP_HLT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == S_EXEC && opcode == OP_ST && opnd_addr != IO_A)
      memory[opnd_addr] <= regfile[rd];
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed self-checking bench for cpu_multicycle; programs are preloaded hierarchically.
module tb_cpu_multicycle;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       halted, illegal, retire, io_valid;
  logic [7:0] pc_out, io_data;

  int checks = 0;
  int errors = 0;
  int retire_cnt = 0;
  int io_cnt = 0;

  always #5 clk = ~clk;

  cpu_multicycle #(.DATA_W(8), .ADDR_W(8), .REG_CNT(4), .IO_ADDR(255)) dut (
    .clk      (clk),
    .reset    (reset),
    .halted   (halted),
    .illegal  (illegal),
    .pc_out   (pc_out),
    .retire   (retire),
    .io_valid (io_valid),
    .io_data  (io_data)
  );

  // Advance n cycles, sampling on the falling edge and tallying pulses.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (retire)   retire_cnt++;
      if (io_valid) io_cnt++;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) dut.memory[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    retire_cnt = 0;
    io_cnt = 0;
  endtask

  task automatic test_reset();
    clear_mem();
    reset = 1'b0;
    step(7);
    do_reset();
    checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc_out); end
    checks++; if ({halted, illegal, retire, io_valid} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got %b want 0000", {halted, illegal, retire, io_valid}); end
    checks++; if (io_data !== 8'h00) begin errors++; $display("FAIL reset_io_data: got %h want 00", io_data); end
    checks++; if (dut.regfile[2] !== 8'h00) begin errors++; $display("FAIL reset_r2: got %h want 00", dut.regfile[2]); end
  endtask

  task automatic test_basic();
    clear_mem();
    dut.memory[0] = 8'h90; dut.memory[1] = 8'h05; dut.memory[2] = 8'h94; dut.memory[3] = 8'h01;
    dut.memory[4] = 8'h31; dut.memory[5] = 8'h20; dut.memory[6] = 8'h13; dut.memory[7] = 8'hF0;
    do_reset();
    step(17);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL basic_halt_early: got %b want 0", halted); end
    step(1);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL basic_halt_18: got %b want 1", halted); end
    checks++; if (dut.memory[8'h13] !== 8'h06) begin errors++; $display("FAIL basic_mem13: got %h want 06", dut.memory[8'h13]); end
    checks++; if (dut.regfile[0] !== 8'h06) begin errors++; $display("FAIL basic_r0: got %h want 06", dut.regfile[0]); end
    checks++; if (dut.regfile[1] !== 8'h01) begin errors++; $display("FAIL basic_r1: got %h want 01", dut.regfile[1]); end
    checks++; if (retire_cnt !== 5) begin errors++; $display("FAIL basic_retire: got %0d want 5", retire_cnt); end
    checks++; if (pc_out !== 8'h08) begin errors++; $display("FAIL basic_pc: got %h want 08", pc_out); end
    step(3);
    checks++; if (retire_cnt !== 5 || halted !== 1'b1) begin errors++;
      $display("FAIL basic_absorb: retire %0d halted %b want 5 1", retire_cnt, halted); end
  endtask

  task automatic test_carry_branch(input logic [7:0] init, input logic exp_c,
                                   input logic [7:0] exp_r0, input logic [7:0] exp_pc);
    clear_mem();
    dut.memory[0] = 8'h90; dut.memory[1] = init; dut.memory[2] = 8'h94; dut.memory[3] = 8'h01;
    dut.memory[4] = 8'h31; dut.memory[5] = 8'hC0; dut.memory[6] = 8'h20; dut.memory[7] = 8'hF0;
    dut.memory[8'h20] = 8'hF0;
    do_reset();
    step(25);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL carry_halted: got %b want 1", halted); end
    checks++; if (dut.regfile[0] !== exp_r0) begin errors++; $display("FAIL carry_r0: got %h want %h", dut.regfile[0], exp_r0); end
    checks++; if (dut.cf !== exp_c) begin errors++; $display("FAIL carry_c: got %b want %b", dut.cf, exp_c); end
    checks++; if (dut.zf !== (exp_r0 == 8'h00)) begin errors++; $display("FAIL carry_z: got %b want %b", dut.zf, exp_r0 == 8'h00); end
    checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL carry_pc: got %h want %h", pc_out, exp_pc); end
  endtask

  task automatic test_loop_io();
    clear_mem();
    dut.memory[0]  = 8'h90; dut.memory[1]  = 8'h03; dut.memory[2]  = 8'h94; dut.memory[3]  = 8'h01;
    dut.memory[4]  = 8'h41; dut.memory[5]  = 8'hB0; dut.memory[6]  = 8'h0A; dut.memory[7]  = 8'hA0;
    dut.memory[8]  = 8'h04; dut.memory[10] = 8'h98; dut.memory[11] = 8'hA5; dut.memory[12] = 8'h28;
    dut.memory[13] = 8'hFF; dut.memory[14] = 8'hF0; dut.memory[255] = 8'h5A;
    do_reset();
    step(47);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL loop_halt_early: got %b want 0", halted); end
    step(1);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL loop_halt: got %b want 1", halted); end
    checks++; if (dut.regfile[0] !== 8'h00) begin errors++; $display("FAIL loop_r0: got %h want 00", dut.regfile[0]); end
    checks++; if (retire_cnt !== 13) begin errors++; $display("FAIL loop_retire: got %0d want 13", retire_cnt); end
    checks++; if (io_cnt !== 1) begin errors++; $display("FAIL io_pulses: got %0d want 1", io_cnt); end
    checks++; if (io_data !== 8'hA5) begin errors++; $display("FAIL io_data: got %h want a5", io_data); end
    checks++; if (dut.memory[255] !== 8'h5A) begin errors++; $display("FAIL io_mem_ff: got %h want 5a", dut.memory[255]); end
    checks++; if (pc_out !== 8'h0F) begin errors++; $display("FAIL loop_pc: got %h want 0f", pc_out); end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    dut.memory[0] = 8'hA0; dut.memory[1] = 8'hFF; dut.memory[255] = 8'h00;
    do_reset();
    step(4);
    checks++; if (pc_out !== 8'hFF) begin errors++; $display("FAIL wrap_jmp_pc: got %h want ff", pc_out); end
    dut.memory[0] = 8'hF0;
    step(1);
    checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL wrap_pc0: got %h want 00", pc_out); end
    step(5);
    checks++; if (halted !== 1'b1 || pc_out !== 8'h01) begin errors++;
      $display("FAIL wrap_halt: halted %b pc %h want 1 01", halted, pc_out); end
    checks++; if (retire_cnt !== 3) begin errors++; $display("FAIL wrap_retire: got %0d want 3", retire_cnt); end
  endtask

  task automatic test_reset_mid_st();
    clear_mem();
    dut.memory[0] = 8'h94; dut.memory[1] = 8'h77; dut.memory[2] = 8'h24; dut.memory[3] = 8'h40;
    dut.memory[4] = 8'hF0; dut.memory[8'h40] = 8'h33;
    do_reset();
    step(6);
    checks++; if (dut.state !== S_OPERAND) begin errors++; $display("FAIL midst_state: got %0d want %0d", dut.state, S_OPERAND); end
    reset = 1'b1;
    step(1);
    checks++; if ({halted, illegal, retire, io_valid} !== 4'b0000 || io_data !== 8'h00 || pc_out !== 8'h00) begin errors++;
      $display("FAIL midst_outputs: flags %b io_data %h pc %h want 0000 00 00",
               {halted, illegal, retire, io_valid}, io_data, pc_out); end
    checks++; if (dut.regfile[1] !== 8'h00) begin errors++; $display("FAIL midst_r1: got %h want 00", dut.regfile[1]); end
    reset = 1'b0;
    step(1);
    checks++; if (dut.memory[8'h40] !== 8'h33) begin errors++; $display("FAIL midst_mem: got %h want 33", dut.memory[8'h40]); end
    checks++; if (pc_out !== 8'h01) begin errors++; $display("FAIL midst_restart_pc: got %h want 01", pc_out); end
    step(15);
    checks++; if (halted !== 1'b1 || dut.memory[8'h40] !== 8'h77) begin errors++;
      $display("FAIL midst_rerun: halted %b mem %h want 1 77", halted, dut.memory[8'h40]); end
  endtask

  task automatic test_reserved();
    clear_mem();
    dut.memory[0] = 8'hD0; dut.memory[1] = 8'hF0;
    do_reset();
`ifdef CPU_ILLEGAL_TRAP_EN
    step(2);
    checks++; if (halted !== 1'b1 || illegal !== 1'b1) begin errors++;
      $display("FAIL trap_flags: halted %b illegal %b want 1 1", halted, illegal); end
    step(4);
    checks++; if (retire_cnt !== 0) begin errors++; $display("FAIL trap_retire: got %0d want 0", retire_cnt); end
    checks++; if (pc_out !== 8'h01) begin errors++; $display("FAIL trap_pc: got %h want 01", pc_out); end
`else
    step(6);
    checks++; if (halted !== 1'b1 || illegal !== 1'b0) begin errors++;
      $display("FAIL rsv_flags: halted %b illegal %b want 1 0", halted, illegal); end
    checks++; if (retire_cnt !== 2) begin errors++; $display("FAIL rsv_retire: got %0d want 2", retire_cnt); end
    checks++; if (pc_out !== 8'h02) begin errors++; $display("FAIL rsv_pc: got %h want 02", pc_out); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry_branch(8'hFF, 1'b1, 8'h00, 8'h21);
    test_carry_branch(8'hFE, 1'b0, 8'hFF, 8'h08);
    test_loop_io();
    test_pc_wrap();
    test_reset_mid_st();
    test_reserved();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised successor to the team's 8-bit single-file teaching CPU.
- Multi-cycle FSM core with internal unified program/data memory and a parametric register file.
- Register, memory and data widths are generalised; adds Z/C flags, conditional branches, immediates, HLT, a memory-mapped output port and a retire pulse.
- Top-level of the CPU sandbox; benches preload memory hierarchically.

Parameters:
- DATA_W, 8, width of registers and memory words (≥8); the instruction is the low 8 bits of the fetched word.
- ADDR_W, 8, address width; memory depth is 2^ADDR_W words (ADDR_W ≤ DATA_W).
- REG_CNT, 4, number of general registers; fixed at 4 by the 2-bit register fields.
- IO_ADDR, 2^ADDR_W-1, store address mapped to the output port instead of memory.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- halted  out  1  sticky; set after HLT (or trap).
- illegal  out  1  sticky; illegal opcode trapped (see Optional Feature).
- pc_out  out  ADDR_W  current PC.
- retire  out  1  one-cycle pulse per completed instruction.
- io_valid  out  1  one-cycle pulse on a store to IO_ADDR.
- io_data  out  DATA_W  stored value; holds until the next IO store.

Behaviour:
- Internal arrays keep the hierarchical names memory[0:2^ADDR_W-1], regfile[0:3], PC and instr, so benches can preload and peek them.
- memory is never reset; read is combinational.
- Encoding: instr[7:4] opcode, [3:2] rd, [1:0] rs. Two-word ops take the next word as operand; its low ADDR_W bits are used as the address.
- Opcodes:
  - 0 NOP
  - 1 LD rd,[a]
  - 2 ST rd,[a]
  - 3 ADD rd,rs
  - 4 SUB rd,rs
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 MOV rd,rs
  - 9 LDI rd,#imm
  - A JMP a
  - B JZ a
  - C JC a
  - D/E reserved
  - F HLT
- Two-word ops: 1, 2, 9, A, B, C.
- FSM states: FETCH → DECODE → (OPERAND if two-word) → EXEC → FETCH; HLT → HALT.
  - FETCH: instr ← memory[PC], PC ← PC+1.
  - OPERAND: opnd ← memory[PC], PC ← PC+1.
  - EXEC: performs the operation and pulses retire.
  - HALT: absorbing until reset; retire pulses once on the HLT EXEC cycle.
- Latency:
  - 1-word op: 3 cycles (incl. HLT).
  - 2-word op: 4 cycles.
  - Taken and not-taken branches cost the same.
- Arithmetic: mod 2^DATA_W.
  - ADD: C = carry out.
  - SUB: C = borrow (rd<rs unsigned).
  - AND/OR/XOR: clear C.
  - ADD/SUB/AND/OR/XOR set Z = (result==0).
  - LD/LDI/MOV/ST/branches leave flags unchanged.
- PC increments wrap 2^ADDR_W-1 → 0; an operand fetched at the top address wraps the same way.
- ST to IO_ADDR: io_data ← rd, io_valid = 1 for the EXEC cycle; memory[IO_ADDR] is not written. LD from IO_ADDR reads memory normally.
- Reset (any state, incl. mid-instruction):
  - PC=0, regfile=0, Z=C=0, state FETCH.
  - halted=illegal=retire=io_valid=0, io_data=0.
  - Any in-flight store is dropped.

Optional Feature:
- Macro CPU_ILLEGAL_TRAP_EN.
- Defined: opcodes D/E in DECODE go to HALT with illegal=1 and halted=1; no retire pulse; no state change other than the PC already incremented.
- Undefined: D/E execute as 1-word NOPs (retire pulses); illegal tied to 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_NOP…OP_HLT);
  - FSM state enum (S_FETCH, S_DECODE, S_OPERAND, S_EXEC, S_HALT);
  - function is_two_word(opcode).
- One sub-module, cpu_alu: combinational DATA_W ALU taking op, a, b and producing result, z, c. Everything else stays in the top.

Test Plan:
- Memory 0x90,05,0x94,01,0x31,0x20,0x13,0xF0; reset held 1 cycle → mem[0x13]=6, R0=6, R1=1, 5 retire pulses, halted=1 exactly 18 cycles after reset release, PC=8.
- Carry/branch: LDI R0,#0xFF; LDI R1,#1; ADD R0,R1; JC 0x20 → R0=0, Z=1, C=1, PC reaches 0x20; repeat with 0xFE → C=0, branch not taken.
- Countdown loop: R0=3, R1=1; SUB then JZ exit / JMP loop → exits after 3 iterations, R0=0. Also test ST to IO_ADDR (0xFF) with R2=0xA5 → io_valid single pulse, io_data=0xA5, mem[0xFF] unchanged.
- PC wrap: JMP 0xFF, where mem[0xFF]=0x00 (NOP) and mem[0]=0xF0 → executes NOP at 0xFF, wraps, halts at PC=1.
- Reset mid-ST (assert in OPERAND) → target memory unchanged, all outputs 0 next cycle, program restarts from PC=0.
- Opcode 0xD0: with CPU_ILLEGAL_TRAP_EN → illegal=halted=1, no retire; without it → NOP, execution continues.
